// File: rtl/ball_camera_ctrl.sv
// ball_camera_ctrl: per-frame pose integrator feeding the perspective map renderer.
// Once per frame_start (vblank) the player buttons are latched, heading and speed
// are updated, the ball is advanced along the heading using cos_sin_lookup, the
// position is clamped to the map, and the whole pose is committed on one edge.
// Optional feature macro: BALL_BOUNCE_EN (wall hits reflect the heading and keep
// speed instead of stopping the ball).

// cos_sin_lookup: 1-cycle latency sine/cosine for integer degrees 0..359.
// Outputs are Q8.8 magnitudes (0..256) plus sign bits.
module cos_sin_lookup (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic [8:0] ang,
    output logic [8:0] cos_abs,
    output logic [8:0] sin_abs,
    output logic       cos_neg,
    output logic       sin_neg
);

    // round(256*sin(d)) for d = 0..90 degrees
    function automatic logic [8:0] quarter_sin(input logic [6:0] d);
        logic [8:0] v;
        case (d)
            7'd0:  v = 9'd0;   7'd1:  v = 9'd4;   7'd2:  v = 9'd9;   7'd3:  v = 9'd13;
            7'd4:  v = 9'd18;  7'd5:  v = 9'd22;  7'd6:  v = 9'd27;  7'd7:  v = 9'd31;
            7'd8:  v = 9'd36;  7'd9:  v = 9'd40;  7'd10: v = 9'd44;  7'd11: v = 9'd49;
            7'd12: v = 9'd53;  7'd13: v = 9'd58;  7'd14: v = 9'd62;  7'd15: v = 9'd66;
            7'd16: v = 9'd71;  7'd17: v = 9'd75;  7'd18: v = 9'd79;  7'd19: v = 9'd83;
            7'd20: v = 9'd88;  7'd21: v = 9'd92;  7'd22: v = 9'd96;  7'd23: v = 9'd100;
            7'd24: v = 9'd104; 7'd25: v = 9'd108; 7'd26: v = 9'd112; 7'd27: v = 9'd116;
            7'd28: v = 9'd120; 7'd29: v = 9'd124; 7'd30: v = 9'd128; 7'd31: v = 9'd132;
            7'd32: v = 9'd136; 7'd33: v = 9'd139; 7'd34: v = 9'd143; 7'd35: v = 9'd147;
            7'd36: v = 9'd150; 7'd37: v = 9'd154; 7'd38: v = 9'd158; 7'd39: v = 9'd161;
            7'd40: v = 9'd165; 7'd41: v = 9'd168; 7'd42: v = 9'd171; 7'd43: v = 9'd175;
            7'd44: v = 9'd178; 7'd45: v = 9'd181; 7'd46: v = 9'd184; 7'd47: v = 9'd187;
            7'd48: v = 9'd190; 7'd49: v = 9'd193; 7'd50: v = 9'd196; 7'd51: v = 9'd199;
            7'd52: v = 9'd202; 7'd53: v = 9'd204; 7'd54: v = 9'd207; 7'd55: v = 9'd210;
            7'd56: v = 9'd212; 7'd57: v = 9'd215; 7'd58: v = 9'd217; 7'd59: v = 9'd219;
            7'd60: v = 9'd222; 7'd61: v = 9'd224; 7'd62: v = 9'd226; 7'd63: v = 9'd228;
            7'd64: v = 9'd230; 7'd65: v = 9'd232; 7'd66: v = 9'd234; 7'd67: v = 9'd236;
            7'd68: v = 9'd237; 7'd69: v = 9'd239; 7'd70: v = 9'd241; 7'd71: v = 9'd242;
            7'd72: v = 9'd243; 7'd73: v = 9'd245; 7'd74: v = 9'd246; 7'd75: v = 9'd247;
            7'd76: v = 9'd248; 7'd77: v = 9'd249; 7'd78: v = 9'd250; 7'd79: v = 9'd251;
            7'd80: v = 9'd252; 7'd81: v = 9'd253; 7'd82: v = 9'd254; 7'd83: v = 9'd254;
            7'd84: v = 9'd255; 7'd85: v = 9'd255; 7'd86: v = 9'd255; 7'd87: v = 9'd256;
            7'd88: v = 9'd256; 7'd89: v = 9'd256; 7'd90: v = 9'd256;
            default: v = 9'd0;
        endcase
        return v;
    endfunction

    logic [6:0] sin_idx_s;
    logic [6:0] cos_idx_s;
    logic       sin_neg_s;
    logic       cos_neg_s;

    // Fold the angle into the first quadrant and derive the signs
    always_comb begin
        sin_idx_s = 7'd0;
        cos_idx_s = 7'd90;
        sin_neg_s = 1'b0;
        cos_neg_s = 1'b0;
        if (ang <= 9'd90) begin
            sin_idx_s = ang[6:0];
            cos_idx_s = 7'(9'd90 - ang);
            sin_neg_s = 1'b0;
            cos_neg_s = 1'b0;
        end else if (ang <= 9'd180) begin
            sin_idx_s = 7'(9'd180 - ang);
            cos_idx_s = 7'(ang - 9'd90);
            sin_neg_s = 1'b0;
            cos_neg_s = 1'b1;
        end else if (ang <= 9'd270) begin
            sin_idx_s = 7'(ang - 9'd180);
            cos_idx_s = 7'(9'd270 - ang);
            sin_neg_s = 1'b1;
            cos_neg_s = 1'b1;
        end else begin
            sin_idx_s = 7'(9'd360 - ang);
            cos_idx_s = 7'(ang - 9'd270);
            sin_neg_s = 1'b1;
            cos_neg_s = 1'b0;
        end
    end

    // Register the table outputs (one cycle of latency)
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            cos_abs <= 9'd0;
            sin_abs <= 9'd0;
            cos_neg <= 1'b0;
            sin_neg <= 1'b0;
        end else begin
            cos_abs <= quarter_sin(cos_idx_s);
            sin_abs <= quarter_sin(sin_idx_s);
            cos_neg <= cos_neg_s;
            sin_neg <= sin_neg_s;
        end
    end

endmodule

module ball_camera_ctrl #(
    parameter int          MAP_W     = 160,
    parameter int          MAP_H     = 90,
    parameter int          ANG_STEP  = 2,
    parameter int          ACCEL     = 16,
    parameter int          FRICTION  = 4,
    parameter int          BRAKE     = 32,
    parameter int          MAX_SPEED = 256,
    parameter logic [15:0] START_X   = 16'h5000,
    parameter logic [15:0] START_Y   = 16'h2D00,
    parameter int          START_ANG = 180
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_start,
    input  logic        btn_fwd,
    input  logic        btn_brake,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [15:0] ballx,
    output logic [15:0] bally,
    output logic [15:0] angle,
    output logic [15:0] speed_out,
    output logic        pose_valid,
    output logic        busy
);

    localparam logic signed [17:0] X_MAX_S  = 18'((MAP_W << 8) - 1);
    localparam logic signed [17:0] Y_MAX_S  = 18'((MAP_H << 8) - 1);
    localparam logic [8:0]         STEP_W   = 9'(ANG_STEP);
    localparam logic [16:0]        ACCEL_W  = 17'(ACCEL);
    localparam logic [15:0]        FRIC_W   = 16'(FRICTION);
    localparam logic [15:0]        BRAKE_W  = 16'(BRAKE);
    localparam logic [16:0]        MAXSPD_W = 17'(MAX_SPEED);
    localparam logic [8:0]         ANG0_W   = 9'(START_ANG);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROTATE = 3'd1,
        S_LOOKUP = 3'd2,
        S_MOVE   = 3'd3,
        S_CLAMP  = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t             state_r;
    logic               btn_fwd_r;
    logic               btn_brake_r;
    logic               btn_left_r;
    logic               btn_right_r;
    logic [8:0]         ang_work_r;
    logic [15:0]        spd_work_r;
    logic signed [17:0] x_work_r;
    logic signed [17:0] y_work_r;

    logic [8:0]         ang_next_s;
    logic [16:0]        spd_sum_s;
    logic [15:0]        spd_next_s;
    logic [8:0]         cos_abs_s;
    logic [8:0]         sin_abs_s;
    logic               cos_neg_s;
    logic               sin_neg_s;
    logic [15:0]        mag_x_s;
    logic [15:0]        mag_y_s;
    logic signed [17:0] dx_s;
    logic signed [17:0] dy_s;
    logic signed [17:0] x_sum_s;
    logic signed [17:0] y_sum_s;
    logic signed [17:0] x_clamp_s;
    logic signed [17:0] y_clamp_s;
    logic               hit_x_s;
    logic               hit_y_s;

    cos_sin_lookup u_lookup (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .ang          (ang_work_r),
        .cos_abs      (cos_abs_s),
        .sin_abs      (sin_abs_s),
        .cos_neg      (cos_neg_s),
        .sin_neg      (sin_neg_s)
    );

    // Heading update from the latched turn buttons, wrapping through 0/360
    always_comb begin
        ang_next_s = angle[8:0];
        if (btn_left_r && !btn_right_r) begin
            if ((angle[8:0] + STEP_W) >= 9'd360) begin
                ang_next_s = angle[8:0] + STEP_W - 9'd360;
            end else begin
                ang_next_s = angle[8:0] + STEP_W;
            end
        end else if (btn_right_r && !btn_left_r) begin
            if (angle[8:0] < STEP_W) begin
                ang_next_s = angle[8:0] + 9'd360 - STEP_W;
            end else begin
                ang_next_s = angle[8:0] - STEP_W;
            end
        end else begin
            ang_next_s = angle[8:0];
        end
    end

    // Speed update: forward beats brake, otherwise friction; saturate at both ends
    always_comb begin
        spd_sum_s  = {1'b0, speed_out} + ACCEL_W;
        spd_next_s = speed_out;
        if (btn_fwd_r) begin
            if (spd_sum_s > MAXSPD_W) begin
                spd_next_s = MAXSPD_W[15:0];
            end else begin
                spd_next_s = spd_sum_s[15:0];
            end
        end else if (btn_brake_r) begin
            if (speed_out < BRAKE_W) begin
                spd_next_s = 16'd0;
            end else begin
                spd_next_s = speed_out - BRAKE_W;
            end
        end else begin
            if (speed_out < FRIC_W) begin
                spd_next_s = 16'd0;
            end else begin
                spd_next_s = speed_out - FRIC_W;
            end
        end
    end

    // Displacement: dx = -cos, dy = +sin, magnitude taken before the sign
    always_comb begin
        mag_x_s = 16'((32'(spd_work_r) * 32'(cos_abs_s)) >> 8);
        mag_y_s = 16'((32'(spd_work_r) * 32'(sin_abs_s)) >> 8);
        if (cos_neg_s) begin
            dx_s = $signed({2'b00, mag_x_s});
        end else begin
            dx_s = 18'sd0 - $signed({2'b00, mag_x_s});
        end
        if (sin_neg_s) begin
            dy_s = 18'sd0 - $signed({2'b00, mag_y_s});
        end else begin
            dy_s = $signed({2'b00, mag_y_s});
        end
        x_sum_s = $signed({2'b00, ballx}) + dx_s;
        y_sum_s = $signed({2'b00, bally}) + dy_s;
    end

    // Per-axis clamp to the map and wall-hit detection
    always_comb begin
        hit_x_s   = 1'b0;
        hit_y_s   = 1'b0;
        x_clamp_s = x_work_r;
        y_clamp_s = y_work_r;
        if (x_work_r < 18'sd0) begin
            x_clamp_s = 18'sd0;
            hit_x_s   = 1'b1;
        end else if (x_work_r > X_MAX_S) begin
            x_clamp_s = X_MAX_S;
            hit_x_s   = 1'b1;
        end else begin
            x_clamp_s = x_work_r;
            hit_x_s   = 1'b0;
        end
        if (y_work_r < 18'sd0) begin
            y_clamp_s = 18'sd0;
            hit_y_s   = 1'b1;
        end else if (y_work_r > Y_MAX_S) begin
            y_clamp_s = Y_MAX_S;
            hit_y_s   = 1'b1;
        end else begin
            y_clamp_s = y_work_r;
            hit_y_s   = 1'b0;
        end
    end

`ifdef BALL_BOUNCE_EN
    logic [8:0] ang_reflect_s;

    // Reflected heading: x wall mirrors about 90, y wall about 0, corner reverses
    always_comb begin
        ang_reflect_s = ang_work_r;
        if (hit_x_s && hit_y_s) begin
            if (ang_work_r < 9'd180) begin
                ang_reflect_s = ang_work_r + 9'd180;
            end else begin
                ang_reflect_s = ang_work_r - 9'd180;
            end
        end else if (hit_x_s) begin
            if (ang_work_r <= 9'd180) begin
                ang_reflect_s = 9'd180 - ang_work_r;
            end else begin
                ang_reflect_s = 9'(10'd540 - 10'(ang_work_r));
            end
        end else if (hit_y_s) begin
            if (ang_work_r == 9'd0) begin
                ang_reflect_s = 9'd0;
            end else begin
                ang_reflect_s = 9'd360 - ang_work_r;
            end
        end else begin
            ang_reflect_s = ang_work_r;
        end
    end
`endif

    // Frame FSM: IDLE -> ROTATE -> LOOKUP -> MOVE -> CLAMP -> COMMIT, registered outputs
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r     <= S_IDLE;
            btn_fwd_r   <= 1'b0;
            btn_brake_r <= 1'b0;
            btn_left_r  <= 1'b0;
            btn_right_r <= 1'b0;
            ang_work_r  <= ANG0_W;
            spd_work_r  <= 16'd0;
            x_work_r    <= 18'sd0;
            y_work_r    <= 18'sd0;
            ballx       <= START_X;
            bally       <= START_Y;
            angle       <= {7'd0, ANG0_W};
            speed_out   <= 16'd0;
            pose_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pose_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (frame_start) begin
                        btn_fwd_r   <= btn_fwd;
                        btn_brake_r <= btn_brake;
                        btn_left_r  <= btn_left;
                        btn_right_r <= btn_right;
                        busy        <= 1'b1;
                        state_r     <= S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    ang_work_r <= ang_next_s;
                    spd_work_r <= spd_next_s;
                    state_r    <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    state_r <= S_MOVE;
                end
                S_MOVE: begin
                    x_work_r <= x_sum_s;
                    y_work_r <= y_sum_s;
                    state_r  <= S_CLAMP;
                end
                S_CLAMP: begin
                    x_work_r <= x_clamp_s;
                    y_work_r <= y_clamp_s;
`ifdef BALL_BOUNCE_EN
                    ang_work_r <= ang_reflect_s;
`else
                    if (hit_x_s || hit_y_s) begin
                        spd_work_r <= 16'd0;
                    end
`endif
                    state_r <= S_COMMIT;
                end
                S_COMMIT: begin
                    ballx      <= x_work_r[15:0];
                    bally      <= y_work_r[15:0];
                    angle      <= {7'd0, ang_work_r};
                    speed_out  <= spd_work_r;
                    pose_valid <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_camera_ctrl.sv
// Scoreboard bench for ball_camera_ctrl: each frame issued pushes the expected
// pose from a small behavioural model; a monitor pops and compares on pose_valid.
// Key frames are additionally checked against hand-computed constants.
module tb_ball_camera_ctrl;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic        frame_start;
    logic        btn_fwd;
    logic        btn_brake;
    logic        btn_left;
    logic        btn_right;
    logic [15:0] ballx;
    logic [15:0] bally;
    logic [15:0] angle;
    logic [15:0] speed_out;
    logic        pose_valid;
    logic        busy;

    ball_camera_ctrl dut (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .frame_start  (frame_start),
        .btn_fwd      (btn_fwd),
        .btn_brake    (btn_brake),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .ballx        (ballx),
        .bally        (bally),
        .angle        (angle),
        .speed_out    (speed_out),
        .pose_valid   (pose_valid),
        .busy         (busy)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    typedef struct {
        int x;
        int y;
        int a;
        int s;
    } pose_t;

    pose_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int mx, my, ma, ms;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int trig_mag(input real v);
        real a;
        a = (v < 0.0) ? -v : v;
        return $rtoi(a * 256.0 + 0.5);
    endfunction

    task automatic model_reset();
        mx = 32'h5000;
        my = 32'h2D00;
        ma = 180;
        ms = 0;
    endtask

    task automatic model_step(input bit f, input bit b, input bit l, input bit r);
        int  a, s, cm, sm, dx, dy, x, y;
        bit  hx, hy;
        real rad, c, sn;
        a = ma;
        if (l && !r) begin
            a = a + 2;
            if (a >= 360) a = a - 360;
        end else if (r && !l) begin
            a = (a < 2) ? a + 358 : a - 2;
        end
        s = ms;
        if (f) s = (s + 16 > 256) ? 256 : s + 16;
        else if (b) s = (s < 32) ? 0 : s - 32;
        else s = (s < 4) ? 0 : s - 4;
        rad = a * 3.14159265358979 / 180.0;
        c   = $cos(rad);
        sn  = $sin(rad);
        cm  = trig_mag(c);
        sm  = trig_mag(sn);
        dx  = (s * cm) >>> 8;
        if (c >= 0.0) dx = -dx;
        dy  = (s * sm) >>> 8;
        if (sn < 0.0) dy = -dy;
        x = mx + dx;
        y = my + dy;
        hx = 1'b0;
        hy = 1'b0;
        if (x < 0) begin x = 0; hx = 1'b1; end
        else if (x > 40959) begin x = 40959; hx = 1'b1; end
        if (y < 0) begin y = 0; hy = 1'b1; end
        else if (y > 23039) begin y = 23039; hy = 1'b1; end
        if (hx || hy) begin
`ifdef BALL_BOUNCE_EN
            if (hx && hy) a = (a + 180) % 360;
            else if (hx) a = (540 - a) % 360;
            else a = (360 - a) % 360;
`else
            s = 0;
`endif
        end
        mx = x; my = y; ma = a; ms = s;
        exp_q.push_back('{x, y, a, s});
    endtask

    // Monitor: every committed pose is checked against the scoreboard head
    always @(negedge pixel_clk_in) begin
        pose_t e;
        if (!rst_in && pose_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pose actual=pose_valid expected=no_pose");
            end else begin
                e = exp_q.pop_front();
                chk("pose_x", int'(ballx), e.x);
                chk("pose_y", int'(bally), e.y);
                chk("pose_angle", int'(angle), e.a);
                chk("pose_speed", int'(speed_out), e.s);
            end
        end
    end

    task automatic frame(input bit f, input bit b, input bit l, input bit r);
        int n;
        model_step(f, b, l, r);
        @(negedge pixel_clk_in);
        btn_fwd = f; btn_brake = b; btn_left = l; btn_right = r;
        frame_start = 1'b1;
        @(negedge pixel_clk_in);
        frame_start = 1'b0;
        btn_fwd = 1'b0; btn_brake = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        chk("busy_during", int'(busy), 1);
        n = 1;
        while (!pose_valid && n < 20) begin
            @(negedge pixel_clk_in);
            n++;
        end
        chk("latency", n, 6);
        chk("busy_after", int'(busy), 0);
        @(negedge pixel_clk_in);
        chk("pv_width", int'(pose_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv_cnt;
        rst_in = 1'b1;
        frame_start = 1'b0;
        btn_fwd = 1'b0; btn_brake = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        model_reset();
        repeat (2) @(negedge pixel_clk_in);
        chk("rst_x", int'(ballx), 32'h5000);
        chk("rst_y", int'(bally), 32'h2D00);
        chk("rst_angle", int'(angle), 180);
        chk("rst_speed", int'(speed_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pv", int'(pose_valid), 0);
        rst_in = 1'b0;
        @(negedge pixel_clk_in);

        // first forward frame from reset
        frame(1, 0, 0, 0);
        chk("fwd1_angle", int'(angle), 180);
        chk("fwd1_speed", int'(speed_out), 16);
        chk("fwd1_x", int'(ballx), 32'h5010);
        chk("fwd1_y", int'(bally), 32'h2D00);

        // coast to a stop, then brake at zero speed
        repeat (4) frame(0, 0, 0, 0);
        frame(0, 1, 0, 0);
        chk("stop_speed", int'(speed_out), 0);
        chk("stop_x", int'(ballx), 32'h5028);

        // turning and angle wrap at speed 0
        repeat (89) frame(0, 0, 1, 0);
        chk("turn_358", int'(angle), 358);
        frame(0, 0, 1, 0);
        chk("wrap_left", int'(angle), 0);
        frame(0, 0, 0, 1);
        chk("wrap_right", int'(angle), 358);
        frame(0, 0, 1, 1);
        chk("both_btn", int'(angle), 358);
        repeat (46) frame(0, 0, 1, 0);
        chk("turn_90", int'(angle), 90);

        // accelerate along +y, then one friction frame
        repeat (16) frame(1, 0, 0, 0);
        chk("ramp_speed", int'(speed_out), 256);
        chk("ramp_y", int'(bally), 32'h3580);
        frame(0, 0, 0, 0);
        chk("fric_speed", int'(speed_out), 252);
        chk("fric_y", int'(bally), 32'h367C);
        chk("fric_x", int'(ballx), 32'h5028);
        chk("fric_angle", int'(angle), 90);

        // drive into the y wall
        repeat (35) frame(1, 0, 0, 0);
        chk("pre_ywall_y", int'(bally), 32'h597C);
        frame(1, 0, 0, 0);
        chk("ywall_y", int'(bally), 32'h59FF);
`ifdef BALL_BOUNCE_EN
        chk("ywall_speed", int'(speed_out), 256);
        chk("ywall_angle", int'(angle), 270);
`else
        chk("ywall_speed", int'(speed_out), 0);
        chk("ywall_angle", int'(angle), 90);
`endif

        // reset in the middle of a frame (FSM in MOVE)
        @(negedge pixel_clk_in);
        btn_fwd = 1'b1;
        frame_start = 1'b1;
        @(negedge pixel_clk_in);
        frame_start = 1'b0;
        btn_fwd = 1'b0;
        @(posedge pixel_clk_in);
        @(posedge pixel_clk_in);
        #2;
        chk("mid_busy", int'(busy), 1);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_x", int'(ballx), 32'h5000);
        chk("mid_rst_y", int'(bally), 32'h2D00);
        chk("mid_rst_angle", int'(angle), 180);
        chk("mid_rst_speed", int'(speed_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        model_reset();
        @(negedge pixel_clk_in);
        rst_in = 1'b0;
        @(negedge pixel_clk_in);

        // run along +x into the map edge
        repeat (87) frame(1, 0, 0, 0);
        chk("pre_xwall_x", int'(ballx), 32'h9F80);
        chk("pre_xwall_speed", int'(speed_out), 256);
        frame(1, 0, 0, 0);
        chk("xwall_x", int'(ballx), 32'h9FFF);
`ifdef BALL_BOUNCE_EN
        chk("xwall_angle", int'(angle), 0);
        chk("xwall_speed", int'(speed_out), 256);
`else
        chk("xwall_angle", int'(angle), 180);
        chk("xwall_speed", int'(speed_out), 0);
`endif

        // second frame_start while busy is dropped
        model_step(0, 0, 1, 0);
        @(negedge pixel_clk_in);
        btn_left = 1'b1;
        frame_start = 1'b1;
        @(negedge pixel_clk_in);
        frame_start = 1'b0;
        btn_left = 1'b0;
        @(negedge pixel_clk_in);
        btn_left = 1'b1;
        frame_start = 1'b1;
        @(negedge pixel_clk_in);
        frame_start = 1'b0;
        btn_left = 1'b0;
        pv_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge pixel_clk_in);
            if (pose_valid) pv_cnt++;
        end
        chk("single_pose", pv_cnt, 1);
`ifdef BALL_BOUNCE_EN
        chk("drop_angle", int'(angle), 2);
`else
        chk("drop_angle", int'(angle), 182);
`endif
        chk("drop_busy", int'(busy), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
